script_exec_ctrl: RTL and testbench

Sequencer that owns the script operand stack and drives `AluScript` one opcode at a time. It accepts a command stream of data pushes and opcodes, pops the operands for each opcode into the ALU, waits for `done`/`error`, and pushes the ALU results back. It sits between the script fetch/parse front end and `AluScript`, replacing the behavioural stack model the benches use today.

---
 rtl/script_exec_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_script_exec_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/script_exec_ctrl.sv
// script_exec_ctrl: owns the script operand stack and drives AluScript one
// opcode at a time (IDLE -> LOAD -> WAIT -> PUSH1 -> PUSH2 -> IDLE).
// Optional feature macro: SCRIPT_CTRL_TIMEOUT_EN bounds WAIT to TIMEOUT cycles
// (error code 5); without it WAIT waits indefinitely.
module script_exec_ctrl #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_push,
    input  logic [7:0]                 cmd_opcode,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [7:0]                 opcode,
    output logic                       put_alu_in1,
    output logic                       put_alu_in2,
    output logic [WIDTH-1:0]           data_alu_in1,
    output logic [WIDTH-1:0]           data_alu_in2,
    input  logic                       done,
    input  logic                       error,
    input  logic                       put_alu_out1,
    input  logic                       put_alu_out2,
    input  logic [WIDTH-1:0]           data_alu_out1,
    input  logic [WIDTH-1:0]           data_alu_out2,
    output logic [$clog2(DEPTH+1)-1:0] stack_count,
    output logic [WIDTH-1:0]           stack_top,
    output logic                       busy,
    output logic                       err,
    output logic [2:0]                 err_code
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PUSH1 = 3'd3;
    localparam logic [2:0] ST_PUSH2 = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    localparam logic [2:0] EC_UNDERFLOW = 3'd1;
    localparam logic [2:0] EC_OVERFLOW  = 3'd2;
    localparam logic [2:0] EC_UNSUP     = 3'd3;
    localparam logic [2:0] EC_ALU       = 3'd4;

    // Reject illegal configurations at elaboration.
    if (DEPTH < 4 || DEPTH > 256 || TIMEOUT < 1) begin : g_bad_param
        $error("script_exec_ctrl: DEPTH must be 4..256 and TIMEOUT >= 1");
    end

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             put1_q, put1_d;
    logic             put2_q, put2_d;
    logic [WIDTH-1:0] din1_q, din1_d;
    logic [WIDTH-1:0] din2_q, din2_d;
    logic             arity2_q, arity2_d;
    logic             oflag1_q, oflag1_d;
    logic             oflag2_q, oflag2_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] push_val;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;
    logic [1:0]       cmd_arity;
    logic             full;

`ifdef SCRIPT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    localparam logic [2:0] EC_TIMEOUT = 3'd5;
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Number of stack operands each supported opcode consumes; 0 = unsupported.
    function automatic logic [1:0] op_arity(input logic [7:0] op);
        case (op)
            8'h76, 8'ha8, 8'ha9: op_arity = 2'd1;
            8'h87, 8'h88, 8'hac: op_arity = 2'd2;
            default:             op_arity = 2'd0;
        endcase
    endfunction

    // Stack addressing and status outputs.
    always_comb begin
        top_idx     = AW'(count_q - CW'(1));
        nxt_idx     = AW'(count_q - CW'(2));
        cmd_arity   = op_arity(cmd_opcode);
        full        = (count_q == CW'(DEPTH));
        cmd_ready   = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
        stack_count = count_q;
        stack_top   = (count_q == '0) ? '0 : stack_q[top_idx];
        opcode      = opcode_q;
        put_alu_in1 = put1_q;
        put_alu_in2 = put2_q;
        data_alu_in1 = din1_q;
        data_alu_in2 = din2_q;
        err         = err_q;
        err_code    = err_code_q;
    end

    // Sequencer next-state logic, including the single stack write port.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        opcode_d   = opcode_q;
        put1_d     = put1_q;
        put2_d     = put2_q;
        din1_d     = din1_q;
        din2_d     = din2_q;
        arity2_d   = arity2_q;
        oflag1_d   = oflag1_q;
        oflag2_d   = oflag2_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        push_en    = 1'b0;
        push_idx   = AW'(count_q);
        push_val   = '0;
`ifdef SCRIPT_CTRL_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_push) begin
                        if (full) begin
                            state_d    = ST_ERROR;
                            err_d      = 1'b1;
                            err_code_d = EC_OVERFLOW;
                        end else begin
                            push_en  = 1'b1;
                            push_val = cmd_data;
                            count_d  = count_q + CW'(1);
                        end
                    end else begin
                        opcode_d = cmd_opcode;
                        arity2_d = (cmd_arity == 2'd2);
                        if (cmd_arity == 2'd0) begin
                            state_d    = ST_ERROR;
                            err_d      = 1'b1;
                            err_code_d = EC_UNSUP;
                        end else if (count_q < CW'(cmd_arity)) begin
                            state_d    = ST_ERROR;
                            err_d      = 1'b1;
                            err_code_d = EC_UNDERFLOW;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                din1_d  = stack_q[top_idx];
                din2_d  = arity2_q ? stack_q[nxt_idx] : '0;
                count_d = count_q - (arity2_q ? CW'(2) : CW'(1));
                put1_d  = 1'b1;
                put2_d  = arity2_q;
                state_d = ST_WAIT;
`ifdef SCRIPT_CTRL_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (error) begin
                    put1_d     = 1'b0;
                    put2_d     = 1'b0;
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_code_d = EC_ALU;
                end else if (done) begin
                    put1_d   = 1'b0;
                    put2_d   = 1'b0;
                    oflag1_d = put_alu_out1;
                    oflag2_d = put_alu_out2;
                    out1_d   = data_alu_out1;
                    out2_d   = data_alu_out2;
                    state_d  = ST_PUSH1;
                end
`ifdef SCRIPT_CTRL_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT-1)) begin
                    put1_d     = 1'b0;
                    put2_d     = 1'b0;
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_code_d = EC_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            ST_PUSH1, ST_PUSH2: begin
                state_d = (state_q == ST_PUSH1) ? ST_PUSH2 : ST_IDLE;
                if ((state_q == ST_PUSH1) ? oflag1_q : oflag2_q) begin
                    if (full) begin
                        state_d    = ST_ERROR;
                        err_d      = 1'b1;
                        err_code_d = EC_OVERFLOW;
                    end else begin
                        push_en  = 1'b1;
                        push_val = (state_q == ST_PUSH1) ? out1_q : out2_q;
                        count_d  = count_q + CW'(1);
                    end
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            opcode_q   <= 8'h00;
            put1_q     <= 1'b0;
            put2_q     <= 1'b0;
            din1_q     <= '0;
            din2_q     <= '0;
            arity2_q   <= 1'b0;
            oflag1_q   <= 1'b0;
            oflag2_q   <= 1'b0;
            out1_q     <= '0;
            out2_q     <= '0;
`ifdef SCRIPT_CTRL_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            opcode_q   <= opcode_d;
            put1_q     <= put1_d;
            put2_q     <= put2_d;
            din1_q     <= din1_d;
            din2_q     <= din2_d;
            arity2_q   <= arity2_d;
            oflag1_q   <= oflag1_d;
            oflag2_q   <= oflag2_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
`ifdef SCRIPT_CTRL_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Stack storage; contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            stack_q[push_idx] <= push_val;
        end
    end

endmodule

// File: tb/tb_script_exec_ctrl.sv
// tb_script_exec_ctrl: table-driven command/ALU-response vectors plus
// hand-written sequences for timing, reset-in-WAIT and ignored strobes.
module tb_script_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_push = 1'b0;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [31:0] cmd_data = '0;
    logic [7:0]  opcode;
    logic        put_alu_in1, put_alu_in2;
    logic [31:0] data_alu_in1, data_alu_in2;
    logic        done = 1'b0;
    logic        error = 1'b0;
    logic        put_alu_out1 = 1'b0;
    logic        put_alu_out2 = 1'b0;
    logic [31:0] data_alu_out1 = '0;
    logic [31:0] data_alu_out2 = '0;
    logic [2:0]  stack_count;
    logic [31:0] stack_top;
    logic        busy, err;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    script_exec_ctrl #(.DEPTH(4), .WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_push(cmd_push),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
        .opcode(opcode), .put_alu_in1(put_alu_in1), .put_alu_in2(put_alu_in2),
        .data_alu_in1(data_alu_in1), .data_alu_in2(data_alu_in2),
        .done(done), .error(error),
        .put_alu_out1(put_alu_out1), .put_alu_out2(put_alu_out2),
        .data_alu_out1(data_alu_out1), .data_alu_out2(data_alu_out2),
        .stack_count(stack_count), .stack_top(stack_top),
        .busy(busy), .err(err), .err_code(err_code)
    );

    typedef struct {
        bit          rst_before;
        bit          is_push;
        logic [7:0]  op;
        logic [31:0] data;
        bit          alu_used;
        logic [31:0] exp_in1;
        logic [31:0] exp_in2;
        bit          exp_put2;
        bit          alu_err;
        bit          ov1;
        logic [31:0] o1;
        bit          ov2;
        logic [31:0] o2;
        logic [2:0]  exp_count;
        logic [31:0] exp_top;
        bit          exp_err;
        logic [2:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void add_push(input bit r, input logic [31:0] d,
                                     input logic [2:0] cnt, input logic [31:0] top,
                                     input bit e, input logic [2:0] code);
        vec_t v;
        v = '{default: '0};
        v.rst_before = r; v.is_push = 1'b1; v.data = d;
        v.exp_count = cnt; v.exp_top = top; v.exp_err = e; v.exp_code = code;
        vecs.push_back(v);
    endfunction

    function automatic void add_op(input bit r, input logic [7:0] op, input bit used,
                                   input logic [31:0] in1, input logic [31:0] in2, input bit p2,
                                   input bit aerr, input bit v1, input logic [31:0] o1,
                                   input bit v2, input logic [31:0] o2,
                                   input logic [2:0] cnt, input logic [31:0] top,
                                   input bit e, input logic [2:0] code);
        vec_t v;
        v = '{default: '0};
        v.rst_before = r; v.op = op; v.alu_used = used;
        v.exp_in1 = in1; v.exp_in2 = in2; v.exp_put2 = p2; v.alu_err = aerr;
        v.ov1 = v1; v.o1 = o1; v.ov2 = v2; v.o2 = o2;
        v.exp_count = cnt; v.exp_top = top; v.exp_err = e; v.exp_code = code;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; done = 1'b0; error = 1'b0;
        put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input bit p, input logic [7:0] op, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_push = p; cmd_opcode = op; cmd_data = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_put1(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = put_alu_in1;
        end
        chk({name, " strobe seen"}, {31'b0, got}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Main-function vectors; DEPTH=4 so overflow is cheap to reach.
        add_push(1, 32'hDEAD_BEEF, 3'd1, 32'hDEAD_BEEF, 0, 3'd0);
        add_op  (0, 8'h76, 1, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 3'd2, 32'hDEAD_BEEF, 0, 3'd0);
        add_op  (0, 8'h87, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1, 32'h1, 0, 32'h0, 3'd1, 32'h1, 0, 3'd0);
        add_push(0, 32'h11, 3'd2, 32'h11, 0, 3'd0);
        add_op  (0, 8'hac, 1, 32'h11, 32'h1, 1, 0, 1, 32'hAA, 1, 32'hBB, 3'd2, 32'hBB, 0, 3'd0);
        add_op  (0, 8'ha9, 1, 32'hBB, 32'h0, 0, 0, 0, 32'h0, 1, 32'hCC, 3'd2, 32'hCC, 0, 3'd0);
        add_op  (0, 8'h88, 1, 32'hCC, 32'hAA, 1, 0, 0, 32'h0, 0, 32'h0, 3'd0, 32'h0, 0, 3'd0);
        // Underflow on empty stack and with one operand for a two-operand opcode.
        add_op  (1, 8'h87, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 1, 3'd1);
        add_push(1, 32'h5, 3'd1, 32'h5, 0, 3'd0);
        add_op  (0, 8'h87, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 32'h5, 1, 3'd1);
        // Command-push overflow: fifth push fails, stack frozen.
        add_push(1, 32'h1, 3'd1, 32'h1, 0, 3'd0);
        add_push(0, 32'h2, 3'd2, 32'h2, 0, 3'd0);
        add_push(0, 32'h3, 3'd3, 32'h3, 0, 3'd0);
        add_push(0, 32'h4, 3'd4, 32'h4, 0, 3'd0);
        add_push(0, 32'h5, 3'd4, 32'h4, 1, 3'd2);
        // Result-push overflow: DUP on a full stack, second result overflows.
        add_push(1, 32'hA1, 3'd1, 32'hA1, 0, 3'd0);
        add_push(0, 32'hA2, 3'd2, 32'hA2, 0, 3'd0);
        add_push(0, 32'hA3, 3'd3, 32'hA3, 0, 3'd0);
        add_push(0, 32'hA4, 3'd4, 32'hA4, 0, 3'd0);
        add_op  (0, 8'h76, 1, 32'hA4, 32'h0, 0, 0, 1, 32'hE1, 1, 32'hE2, 3'd4, 32'hE1, 1, 3'd2);
        // Unsupported opcode.
        add_push(1, 32'h7, 3'd1, 32'h7, 0, 3'd0);
        add_op  (0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 32'h7, 1, 3'd3);
        // ALU error together with done.
        add_push(1, 32'h9, 3'd1, 32'h9, 0, 3'd0);
        add_op  (0, 8'ha8, 1, 32'h9, 32'h0, 0, 1, 1, 32'h77, 0, 32'h0, 3'd0, 32'h0, 1, 3'd4);

        // Reset state.
        do_reset();
        chk("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst count", {29'b0, stack_count}, 32'd0);
        chk("rst top", stack_top, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        chk("rst err_code", {29'b0, err_code}, 32'd0);
        chk("rst opcode", {24'b0, opcode}, 32'd0);
        chk("rst strobes", {30'b0, put_alu_in1, put_alu_in2}, 32'd0);
        chk("rst data_in", data_alu_in1 | data_alu_in2, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) begin
            vec_t v;
            string n;
            v = vecs[i];
            n = $sformatf("v%0d", i);
            if (v.rst_before) do_reset();
            send(v.is_push, v.op, v.data);
            if (!v.is_push && v.alu_used) begin
                wait_put1(n);
                chk({n, " in1"}, data_alu_in1, v.exp_in1);
                chk({n, " put2"}, {31'b0, put_alu_in2}, {31'b0, v.exp_put2});
                if (v.exp_put2) chk({n, " in2"}, data_alu_in2, v.exp_in2);
                chk({n, " opcode"}, {24'b0, opcode}, {24'b0, v.op});
                done = 1'b1; error = v.alu_err;
                put_alu_out1 = v.ov1; data_alu_out1 = v.o1;
                put_alu_out2 = v.ov2; data_alu_out2 = v.o2;
                @(posedge clk);
                #1 done = 1'b0; error = 1'b0; put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
            end else if (!v.is_push) begin
                bit seen;
                seen = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    seen = seen | put_alu_in1 | put_alu_in2;
                end
                chk({n, " no strobe"}, {31'b0, seen}, 32'd0);
            end
            begin
                bit fin;
                fin = 1'b0;
                for (int c = 0; c < 10 && !fin; c++) begin
                    @(negedge clk);
                    fin = cmd_ready | err;
                end
                chk({n, " settled"}, {31'b0, fin}, 32'd1);
            end
            chk({n, " count"}, {29'b0, stack_count}, {29'b0, v.exp_count});
            chk({n, " top"}, stack_top, v.exp_top);
            chk({n, " err"}, {31'b0, err}, {31'b0, v.exp_err});
            chk({n, " err_code"}, {29'b0, err_code}, {29'b0, v.exp_code});
            chk({n, " cmd_ready"}, {31'b0, cmd_ready}, {31'b0, !v.exp_err});
        end

        // ERROR is frozen: a push attempt is not accepted.
        send(1'b1, 8'h00, 32'h55);
        @(negedge clk);
        chk("frozen count", {29'b0, stack_count}, 32'd0);
        chk("frozen code", {29'b0, err_code}, 32'd4);
        chk("frozen strobe", {31'b0, put_alu_in1}, 32'd0);

        // Cycle-exact opcode timing with done on the first WAIT cycle.
        do_reset();
        send(1'b1, 8'h00, 32'h42);
        send(1'b0, 8'h76, 32'h0);
        @(negedge clk);
        chk("t1 ready", {31'b0, cmd_ready}, 32'd0);
        chk("t1 strobe", {31'b0, put_alu_in1}, 32'd0);
        @(negedge clk);
        chk("t2 strobe", {31'b0, put_alu_in1}, 32'd1);
        chk("t2 in1", data_alu_in1, 32'h42);
        chk("t2 count", {29'b0, stack_count}, 32'd0);
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        @(negedge clk);
        chk("t3 strobe", {31'b0, put_alu_in1}, 32'd0);
        chk("t3 ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("t4 ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("t5 ready", {31'b0, cmd_ready}, 32'd1);
        chk("t5 busy", {31'b0, busy}, 32'd0);

        // done/error pulsed in IDLE are ignored.
        send(1'b1, 8'h00, 32'h33);
        @(negedge clk);
        done = 1'b1; error = 1'b1; put_alu_out1 = 1'b1; data_alu_out1 = 32'h99;
        @(posedge clk);
        #1 done = 1'b0; error = 1'b0; put_alu_out1 = 1'b0;
        @(negedge clk);
        chk("idle done count", {29'b0, stack_count}, 32'd1);
        chk("idle done err", {31'b0, err}, 32'd0);
        chk("idle done top", stack_top, 32'h33);

        // Reset during WAIT aborts the operation.
        do_reset();
        send(1'b1, 8'h00, 32'h42);
        send(1'b0, 8'ha8, 32'h0);
        wait_put1("rw");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rw ready", {31'b0, cmd_ready}, 32'd1);
        chk("rw count", {29'b0, stack_count}, 32'd0);
        chk("rw strobes", {30'b0, put_alu_in1, put_alu_in2}, 32'd0);
        chk("rw busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;

        // WAIT without done: timeout build errors 8 cycles after entry, default build holds.
        do_reset();
        send(1'b1, 8'h00, 32'h42);
        send(1'b0, 8'ha8, 32'h0);
        wait_put1("to");
`ifdef SCRIPT_CTRL_TIMEOUT_EN
        begin
            int when;
            when = -1;
            for (int c = 1; c <= 12 && when < 0; c++) begin
                @(negedge clk);
                if (err) when = c;
            end
            chk("to cycles", when, 32'd8);
            chk("to code", {29'b0, err_code}, 32'd5);
            chk("to strobe", {31'b0, put_alu_in1}, 32'd0);
        end
`else
        repeat (20) @(negedge clk);
        chk("nto err", {31'b0, err}, 32'd0);
        chk("nto strobe", {31'b0, put_alu_in1}, 32'd1);
        chk("nto busy", {31'b0, busy}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
